// File: rtl/dw_seq_pkg.sv
// Shared types and constants for the two-way decision-wait sequencer.
// Imported by the top and by the z synchroniser.
package dw_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    DRIVE,
    SETUP,
    WAIT_ACK,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_SPURIOUS = 2'd2;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_SETUP_CYC   = 1;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int DEF_TO_W        = 8;

endpackage

// File: rtl/dw_sync.sv
// Multi-flop synchroniser for one asynchronous 2-phase acknowledge line.
// Resets to 0, matching the element's reset phase.
module dw_sync
  import dw_seq_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/dw_sequencer.sv
// Round-robin controller sharing one 2-phase decision-wait element between two
// requesters: selects a channel, fires after a setup delay, waits for the ack.
module dw_sequencer
  import dw_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TO_W        = DEF_TO_W
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       a1,
  output logic       a2,
  output logic       fire,
  input  logic       z1,
  input  logic       z2,
  input  logic       err_clr,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int SU_W = $clog2(SETUP_CYC + 1);

  state_t          r_state, w_state_nxt;
  logic            r_sel, w_sel_nxt;
  logic            r_rr, w_rr_nxt;
  logic [1:0]      r_req_q, w_req_q_nxt;
  logic [1:0]      r_a, w_a_nxt;
  logic            r_fire, w_fire_nxt;
  logic [SU_W-1:0] r_su_cnt, w_su_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_nxt;
  logic [1:0]      r_err_code, w_code_nxt;

  logic            w_z1s, w_z2s;
  logic [1:0]      w_z;
  logic [1:0]      w_req_arb;
  logic            w_a_sel, w_a_oth, w_z_sel, w_z_oth;

  dw_sync #(.STAGES(SYNC_STAGES)) u_sync_z1 (.clk(clk), .rstn(rstn), .d(z1), .q(w_z1s));
  dw_sync #(.STAGES(SYNC_STAGES)) u_sync_z2 (.clk(clk), .rstn(rstn), .d(z2), .q(w_z2s));

  assign w_z = {w_z2s, w_z1s};

  // A request that woke the sequencer still counts even if it drops before ARB.
  assign w_req_arb = req | r_req_q;

  assign w_a_sel = r_sel ? r_a[1] : r_a[0];
  assign w_a_oth = r_sel ? r_a[0] : r_a[1];
  assign w_z_sel = r_sel ? w_z[1] : w_z[0];
  assign w_z_oth = r_sel ? w_z[0] : w_z[1];

  // NOTE: every signal gets a hold default before the case, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rr_nxt    = r_rr;
    w_req_q_nxt = r_req_q;
    w_a_nxt     = r_a;
    w_fire_nxt  = r_fire;
    w_su_nxt    = r_su_cnt;
    w_to_nxt    = r_to_cnt;
    w_code_nxt  = r_err_code;

    unique case (r_state)
      IDLE: begin
        if (|req) begin
          w_req_q_nxt = req;
          w_state_nxt = ARB;
        end
      end
      ARB: begin
        if (w_req_arb == 2'b11) begin
          w_sel_nxt = r_rr;
          w_rr_nxt  = ~r_rr;
        end else begin
          w_sel_nxt = w_req_arb[1];
        end
        w_req_q_nxt = '0;
        w_state_nxt = DRIVE;
      end
      DRIVE: begin
        w_a_nxt[r_sel] = ~r_a[r_sel];
        w_su_nxt       = SU_W'(SETUP_CYC);
        w_state_nxt    = SETUP;
      end
      SETUP: begin
        if (r_su_cnt == '0) begin
          w_fire_nxt  = ~r_fire;
          w_to_nxt    = TO_W'(TIMEOUT_CYC);
          w_state_nxt = WAIT_ACK;
        end else begin
          w_su_nxt = r_su_cnt - 1'b1;
        end
      end
      WAIT_ACK: begin
        // The counter stops at 1 and the state leaves, so it can never wrap.
        if (w_z_oth != w_a_oth) begin
          w_code_nxt  = ERR_SPURIOUS;
          w_state_nxt = ERR;
        end else if (w_z_sel == w_a_sel) begin
          w_state_nxt = DONE;
        end else if (r_to_cnt <= TO_W'(1)) begin
          w_code_nxt  = ERR_TIMEOUT;
          w_state_nxt = ERR;
        end else begin
          w_to_nxt = r_to_cnt - 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      ERR: begin
        if (err_clr) begin
          w_code_nxt  = ERR_NONE;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_sel      <= 1'b0;
      r_rr       <= 1'b0;
      r_req_q    <= '0;
      r_a        <= '0;
      r_fire     <= 1'b0;
      r_su_cnt   <= '0;
      r_to_cnt   <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_rr       <= w_rr_nxt;
      r_req_q    <= w_req_q_nxt;
      r_a        <= w_a_nxt;
      r_fire     <= w_fire_nxt;
      r_su_cnt   <= w_su_nxt;
      r_to_cnt   <= w_to_nxt;
      r_err_code <= w_code_nxt;
    end
  end

  assign a1       = r_a[0];
  assign a2       = r_a[1];
  assign fire     = r_fire;
  assign gnt      = (r_state == DONE) ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
  assign busy     = (r_state != IDLE) && (r_state != ERR);
  assign err      = (r_state == ERR);
  assign err_code = r_err_code;

endmodule

// File: tb/tb_dw_sequencer.sv
// Bench for dw_sequencer: behavioural decision-wait element, directed table,
// randomized transactions against a round-robin model, and error/reset sequences.
`timescale 1ns/1ps
module tb_dw_sequencer;

  localparam int SETUP_CYC   = 1;
  localparam int TIMEOUT_CYC = 10;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       busy, a1, a2, fire, z1, z2, err_clr, err;
  logic [1:0] err_code;

  logic ez1, ez2, spur, elem_en;
  int   elem_dly;
  int   e_cnt;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic m_ptr;

  typedef struct {
    logic [1:0] req;
    int         dly;
    bit         drop;
    logic [1:0] exp_gnt;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  assign z1 = ez1;
  assign z2 = ez2 ^ spur;

  dw_sequencer #(
    .SYNC_STAGES(2),
    .SETUP_CYC  (SETUP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (8)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .gnt(gnt), .busy(busy),
    .a1(a1), .a2(a2), .fire(fire), .z1(z1), .z2(z2),
    .err_clr(err_clr), .err(err), .err_code(err_code)
  );

  // Decision-wait element: a pending select on channel i plus a fire event
  // (fire phase differs from z1^z2) produces a z_i event after elem_dly cycles.
  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      ez1   = 1'b0;
      ez2   = 1'b0;
      e_cnt = 0;
    end else if (elem_en && (fire != (ez1 ^ ez2)) && ((a1 != ez1) || (a2 != ez2))) begin
      if (e_cnt >= elem_dly) begin
        if (a1 != ez1) ez1 = ~ez1;
        else           ez2 = ~ez2;
        e_cnt = 0;
      end else begin
        e_cnt++;
      end
    end else begin
      e_cnt = 0;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Round-robin rule: a lone request wins; a tie goes to the pointer, which then flips.
  function automatic logic [1:0] model_grant(input logic [1:0] r);
    if (r == 2'b11) begin
      model_grant = m_ptr ? 2'b10 : 2'b01;
      m_ptr       = ~m_ptr;
    end else begin
      model_grant = r;
    end
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rstn = 1'b0; req = 2'b00; spur = 1'b0; err_clr = 1'b0; elem_en = 1'b1; elem_dly = 0;
    m_ptr = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run_txn(input logic [1:0] r, input int dly, input bit drop,
                         input logic [1:0] exp_g, input string nm);
    logic       a1_0, a2_0, f_0, pa1, pa2, pf;
    logic [1:0] g_seen;
    int         t_a, t_f, t_g, n_g;
    @(negedge clk);
    a1_0 = a1; a2_0 = a2; f_0 = fire; pa1 = a1; pa2 = a2; pf = fire;
    elem_dly = dly; req = r;
    t_a = -1; t_f = -1; t_g = -1; n_g = 0; g_seen = 2'b00;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (drop && c == 1) req = 2'b00;
      if (t_a < 0 && (a1 != pa1 || a2 != pa2)) t_a = c;
      if (t_f < 0 && fire != pf) t_f = c;
      pa1 = a1; pa2 = a2; pf = fire;
      if (gnt != 2'b00) begin
        n_g++;
        g_seen |= gnt;
        t_g = c;
        req = 2'b00;
      end
      if (t_g > 0 && c >= t_g + 2) break;
    end
    req = 2'b00;
    check({nm, "_gnt"}, int'(g_seen), int'(exp_g));
    check({nm, "_gnt_pulses"}, n_g, 1);
    check({nm, "_a_sel_toggled"}, int'(exp_g[1] ? (a2 ^ a2_0) : (a1 ^ a1_0)), 1);
    check({nm, "_a_other_held"}, int'(exp_g[1] ? (a1 ^ a1_0) : (a2 ^ a2_0)), 0);
    check({nm, "_fire_toggled"}, int'(fire ^ f_0), 1);
    check({nm, "_setup_gap"}, t_f - t_a, SETUP_CYC + 1);
    check({nm, "_busy_after"}, int'(busy), 0);
    check({nm, "_phase_aligned"}, int'({z2, z1} == {a2, a1}), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       f0, a1s, a2s, seen_g;
    int         k;
    bit         found;

    rstn = 1'b0; req = 2'b00; err_clr = 1'b0; spur = 1'b0; elem_en = 1'b1; elem_dly = 0;
    m_ptr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a1", int'(a1), 0);
    check("rst_a2", int'(a2), 0);
    check("rst_fire", int'(fire), 0);
    check("rst_gnt", int'(gnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_code", int'(err_code), 0);
    rstn = 1'b1;

    tbl = '{
      '{2'b11, 0, 1'b0, 2'b01},
      '{2'b11, 1, 1'b0, 2'b10},
      '{2'b11, 2, 1'b0, 2'b01},
      '{2'b11, 0, 1'b0, 2'b10},
      '{2'b01, 3, 1'b0, 2'b01},
      '{2'b10, 1, 1'b0, 2'b10},
      '{2'b01, 2, 1'b1, 2'b01},
      '{2'b11, 0, 1'b1, 2'b01}
    };
    for (int i = 0; i < 8; i++) begin
      void'(model_grant(tbl[i].req));
      run_txn(tbl[i].req, tbl[i].dly, tbl[i].drop, tbl[i].exp_gnt, $sformatf("tbl%0d", i));
      if (i == 3) begin
        check("rr4_fire_end", int'(fire), 0);
        check("rr4_a1_end", int'(a1), 0);
        check("rr4_a2_end", int'(a2), 0);
      end
    end

    for (int i = 0; i < 24; i++) begin
      logic [1:0] r, g;
      r = 2'($urandom_range(1, 3));
      g = model_grant(r);
      run_txn(r, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), g, $sformatf("rnd%0d", i));
    end

    // Timeout: element silent, error must rise TIMEOUT_CYC cycles after fire.
    reset_dut();
    elem_en = 1'b0; req = 2'b01; f0 = fire; found = 1'b0; seen_g = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      req = 2'b00;
      if (fire != f0) found = 1'b1;
    end
    check("to_fire_seen", int'(found), 1);
    k = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (gnt != 2'b00) seen_g = 1'b1;
      if (err) begin
        k = c;
        break;
      end
    end
    check("to_cycles", k, TIMEOUT_CYC);
    check("to_err_code", int'(err_code), 1);
    check("to_busy", int'(busy), 0);
    check("to_no_gnt", int'(seen_g), 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check("to_clr_err", int'(err), 0);
    check("to_clr_code", int'(err_code), 0);
    check("to_clr_busy", int'(busy), 0);

    // Spurious ack on the unselected channel while channel 1 waits.
    reset_dut();
    elem_en = 1'b0; req = 2'b01; f0 = fire; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      req = 2'b00;
      if (fire != f0) found = 1'b1;
    end
    check("sp_fire_seen", int'(found), 1);
    spur = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (err) found = 1'b1;
    end
    check("sp_err", int'(found), 1);
    check("sp_err_code", int'(err_code), 2);
    f0 = fire; a1s = a1; a2s = a2;
    repeat (6) @(negedge clk);
    check("sp_fire_frozen", int'(fire), int'(f0));
    check("sp_a_frozen", int'({a2, a1}), int'({a2s, a1s}));
    check("sp_busy", int'(busy), 0);
    check("sp_err_sticky", int'(err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check("sp_clr_err", int'(err), 0);

    // Reset during SETUP, then a clean channel-2 transaction.
    reset_dut();
    req = 2'b10; a2s = a2; found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (a2 != a2s) found = 1'b1;
    end
    check("mr_a2_seen", int'(found), 1);
    rstn = 1'b0; req = 2'b00;
    #1;
    check("mr_a1", int'(a1), 0);
    check("mr_a2", int'(a2), 0);
    check("mr_fire", int'(fire), 0);
    check("mr_gnt", int'(gnt), 0);
    check("mr_busy", int'(busy), 0);
    @(negedge clk);
    rstn = 1'b1;
    m_ptr = 1'b0;
    run_txn(2'b10, 1, 1'b0, 2'b10, "mr_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
